// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: two-slot load/store sequencer between the MEM stage and
// data_memory. Accepts one bundle of up to two memory operations, computes
// effective addresses, checks alignment and bounds, then performs the
// accesses one at a time with an idle gap between them (data_memory acts on
// enable transitions). Returns extended load data and per-slot fault codes.
//
// Ports (slot k of a 2-slot bus lives at [W*k+W-1 : W*k]):
//   clk, reset          clock / synchronous active-high reset
//   req_valid[1:0]      per-slot operation present
//   req_ready           unit idle, bundle may be presented
//   req_is_store[1:0]   1 = store, 0 = load
//   req_funct3[5:0]     RV64 funct3 per slot
//   req_base[127:0]     rs1 per slot
//   req_offset[127:0]   sign-extended immediate per slot
//   req_wdata[127:0]    rs2 per slot
//   rsp_valid           one-cycle pulse, bundle complete
//   rsp_data[127:0]     extended load result per slot (0 for stores/faults)
//   rsp_fault[3:0]      per slot: 01 misaligned, 10 out of bounds
//   mem_addr, mem_data_input, store_format, load_format,
//   mem_write_en, mem_read_en   registered drive to data_memory
//   mem_data_output     read data from data_memory
//   fsm_state[2:0]      current sequencer state, for observation
//
// Handshake: a bundle is taken on a rising edge where req_ready = 1 and
// req_valid != 0; request inputs are ignored at every other edge. rsp_valid
// is a single-cycle pulse that is never stalled.

module lsu_mem_ctrl #(
    parameter int MEM_BYTES = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_is_store,
    input  logic [5:0]   req_funct3,
    input  logic [127:0] req_base,
    input  logic [127:0] req_offset,
    input  logic [127:0] req_wdata,
    output logic         rsp_valid,
    output logic [127:0] rsp_data,
    output logic [3:0]   rsp_fault,
    output logic [63:0]  mem_addr,
    output logic [63:0]  mem_data_input,
    output logic [1:0]   store_format,
    output logic [2:0]   load_format,
    output logic         mem_write_en,
    output logic         mem_read_en,
    input  logic [63:0]  mem_data_output,
    output logic [2:0]   fsm_state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACC0 = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_ACC1 = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [64:0] BOUND = 65'(MEM_BYTES);

    logic [2:0] state;

    // Slot-1 operation is held for the second access; slot 0 is issued
    // straight from the request inputs at the accept edge.
    logic        s1_valid;
    logic        s1_store;
    logic [2:0]  s1_f3;
    logic [63:0] s1_addr;
    logic [63:0] s1_wdata;
    logic [1:0]  s1_fault;
    logic [2:0]  s0_f3;

    logic [63:0] in_addr0, in_addr1;
    logic [1:0]  in_fault0, in_fault1;

    logic        issue;
    logic [63:0] iss_addr;
    logic [63:0] iss_wdata;
    logic [2:0]  iss_f3;
    logic        iss_store;
    logic [1:0]  iss_fault;

    // Misaligned has priority; the bounds check runs in 65 bits so the last
    // byte address cannot wrap.
    function automatic logic [1:0] fault_of(input logic [63:0] addr, input logic [1:0] sz);
        logic [63:0] mask;
        logic [64:0] last;
        case (sz)
            2'b00:   mask = 64'd0;
            2'b01:   mask = 64'd1;
            2'b10:   mask = 64'd3;
            default: mask = 64'd7;
        endcase
        last = {1'b0, addr} + {1'b0, mask};
        if ((addr & mask) != 64'd0)
            fault_of = 2'b01;
        else if (last >= BOUND)
            fault_of = 2'b10;
        else
            fault_of = 2'b00;
    endfunction

    // Only the low size bytes of the memory read are trusted.
    function automatic logic [63:0] extend(input logic [63:0] d, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   extend = f3[2] ? {56'd0, d[7:0]}  : {{56{d[7]}}, d[7:0]};
            2'b01:   extend = f3[2] ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
            2'b10:   extend = f3[2] ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
            default: extend = d;
        endcase
    endfunction

    assign in_addr0  = req_base[63:0]   + req_offset[63:0];
    assign in_addr1  = req_base[127:64] + req_offset[127:64];
    assign in_fault0 = fault_of(in_addr0, req_funct3[1:0]);
    assign in_fault1 = fault_of(in_addr1, req_funct3[4:3]);

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_DONE);
    assign fsm_state = state;

    // An access is launched on the accept edge (first valid slot) or on the
    // edge leaving GAP (slot 1).
    assign issue = ((state == S_IDLE) && (req_valid != 2'b00)) || (state == S_GAP);

    always_comb begin
        iss_addr  = s1_addr;
        iss_wdata = s1_wdata;
        iss_f3    = s1_f3;
        iss_store = s1_store;
        iss_fault = s1_fault;
        if (state == S_IDLE) begin
            if (req_valid[0]) begin
                iss_addr  = in_addr0;
                iss_wdata = req_wdata[63:0];
                iss_f3    = req_funct3[2:0];
                iss_store = req_is_store[0];
                iss_fault = in_fault0;
            end else begin
                iss_addr  = in_addr1;
                iss_wdata = req_wdata[127:64];
                iss_f3    = req_funct3[5:3];
                iss_store = req_is_store[1];
                iss_fault = in_fault1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            s1_valid       <= 1'b0;
            s1_store       <= 1'b0;
            s1_f3          <= 3'd0;
            s1_addr        <= 64'd0;
            s1_wdata       <= 64'd0;
            s1_fault       <= 2'b00;
            s0_f3          <= 3'd0;
            rsp_data       <= 128'd0;
            rsp_fault      <= 4'd0;
            mem_addr       <= 64'd0;
            mem_data_input <= 64'd0;
            store_format   <= 2'd0;
            load_format    <= 3'd0;
            mem_write_en   <= 1'b0;
            mem_read_en    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid != 2'b00) begin
                        s1_valid  <= req_valid[1];
                        s1_store  <= req_is_store[1];
                        s1_f3     <= req_funct3[5:3];
                        s1_addr   <= in_addr1;
                        s1_wdata  <= req_wdata[127:64];
                        s1_fault  <= in_fault1;
                        s0_f3     <= req_funct3[2:0];
                        rsp_data  <= 128'd0;
                        rsp_fault <= {req_valid[1] ? in_fault1 : 2'b00,
                                      req_valid[0] ? in_fault0 : 2'b00};
                        state     <= req_valid[0] ? S_ACC0 : S_ACC1;
                    end
                end
                S_ACC0: begin
                    // read_en high here implies a non-faulting load
                    if (mem_read_en)
                        rsp_data[63:0] <= extend(mem_data_output, s0_f3);
                    state <= s1_valid ? S_GAP : S_DONE;
                end
                S_GAP: begin
                    state <= S_ACC1;
                end
                S_ACC1: begin
                    if (mem_read_en)
                        rsp_data[127:64] <= extend(mem_data_output, s1_f3);
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Enables last exactly one cycle, so two accesses are always
            // separated by at least one low cycle.
            if (issue) begin
                mem_addr       <= iss_addr;
                mem_data_input <= iss_wdata;
                store_format   <= iss_f3[1:0];
                load_format    <= (iss_f3[1:0] == 2'b11) ? 3'b101 : {1'b0, iss_f3[1:0]};
                mem_write_en   <= iss_store && (iss_fault == 2'b00);
                mem_read_en    <= !iss_store && (iss_fault == 2'b00);
            end else begin
                mem_write_en   <= 1'b0;
                mem_read_en    <= 1'b0;
            end
        end
    end

endmodule
